// File: rtl/linear_row_sequencer_if.sv
// Engine-side bus of the linear row sequencer.
//
// Handshake semantics: the master raises lin_valid together with stable
// lin_weight/lin_bias (lin_vector is constant for a whole run) and keeps all
// of them unchanged until a rising clock edge where lin_valid && lin_ready are
// both high; that edge is the one and only transfer of the row. The slave
// answers each transferred row with exactly one single-cycle lin_done pulse
// carrying lin_result, in the same order the rows were transferred. There is
// no back-pressure on lin_done.
//
// Signals:
//   lin_valid  - row presented (master -> slave)
//   lin_ready  - engine can accept a row (slave -> master)
//   lin_vector - input vector x, 32 x fp32 (master -> slave)
//   lin_weight - weight row, 32 x fp32 (master -> slave)
//   lin_bias   - bias for the row, fp32 (master -> slave)
//   lin_done   - result valid pulse (slave -> master)
//   lin_result - fp32 result (slave -> master)
interface linear_row_sequencer_if;
  logic              lin_valid;
  logic              lin_ready;
  logic [31:0][31:0] lin_vector;
  logic [31:0][31:0] lin_weight;
  logic [31:0]       lin_bias;
  logic              lin_done;
  logic [31:0]       lin_result;

  modport master (
    output lin_valid, lin_vector, lin_weight, lin_bias,
    input  lin_ready, lin_done, lin_result
  );

  modport slave (
    input  lin_valid, lin_vector, lin_weight, lin_bias,
    output lin_ready, lin_done, lin_result
  );
endinterface

// File: rtl/linear_row_sequencer.sv
// Linear row sequencer: drives a 32-element dot-product engine to compute a
// full matrix-vector product y = W*x + b, one output row per engine request.
// Each row's weights and bias are read from a synchronous row-wide memory,
// registered, and presented to the engine together with the captured input
// vector. Results come back in order and are collected into out_vector.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - begin a run (only looked at in IDLE)
//   in_vector   - input vector x, captured on an accepted start
//   busy        - high whenever not IDLE
//   out_valid   - single-cycle pulse once out_vector is complete
//   out_vector  - collected results, entries >= ROWS stay 0
//   err         - sticky flag for an unexpected lin_done, cleared on start
//   w_rd_en     - weight memory read strobe
//   w_addr      - weight memory row index
//   w_rdata     - weight row, valid the cycle after w_rd_en
//   b_rdata     - bias, same timing as w_rdata
//   lin         - engine bus (master side)
//   dbg_state   - current FSM state, for observation only
module linear_row_sequencer #(
  parameter int ROWS            = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int AW              = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [31:0][31:0]      in_vector,
  output logic                   busy,
  output logic                   out_valid,
  output logic [31:0][31:0]      out_vector,
  output logic                   err,
  output logic                   w_rd_en,
  output logic [AW-1:0]          w_addr,
  input  logic [31:0][31:0]      w_rdata,
  input  logic [31:0]            b_rdata,
  linear_row_sequencer_if.master lin,
  output logic [2:0]             dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]        state;
  logic [5:0]        issue_cnt;
  logic [5:0]        collect_cnt;
  logic [3:0]        outstanding;
  logic              row_valid;
  logic [31:0][31:0] x_vec;
  logic [31:0][31:0] row_weight;
  logic [31:0]       row_bias;

  logic handshake;
  logic take_done;
  logic stray_done;
  logic fetch_go;
  logic last_row;

  // row_valid is only ever set while in ISSUE, so the state term just makes
  // the intent explicit.
  assign handshake  = (state == ISSUE) && row_valid && lin.lin_ready;
  // A result is only expected while a run is active and something is in
  // flight; anything else is dropped and flagged.
  assign take_done  = lin.lin_done && (state != IDLE) && (outstanding != 4'd0);
  assign stray_done = lin.lin_done && !take_done;
  assign fetch_go   = (state == FETCH) && (outstanding < 4'(MAX_OUTSTANDING));
  assign last_row   = (issue_cnt + 6'd1) == 6'(ROWS);

  assign busy       = (state != IDLE);
  assign out_valid  = (state == FIN);
  assign w_rd_en    = fetch_go;
  assign w_addr     = AW'(issue_cnt);
  assign dbg_state  = state;

  assign lin.lin_valid  = row_valid;
  assign lin.lin_vector = x_vec;
  assign lin.lin_weight = row_weight;
  assign lin.lin_bias   = row_bias;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      collect_cnt <= '0;
      outstanding <= '0;
      row_valid   <= 1'b0;
      x_vec       <= '0;
      row_weight  <= '0;
      row_bias    <= '0;
      out_vector  <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_vec       <= in_vector;
            issue_cnt   <= '0;
            collect_cnt <= '0;
            outstanding <= '0;
            out_vector  <= '0;
            err         <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          // The read is issued combinationally this cycle; data arrives in
          // the first ISSUE cycle.
          if (fetch_go) state <= ISSUE;
        end
        ISSUE: begin
          if (!row_valid) begin
            row_weight <= w_rdata;
            row_bias   <= b_rdata;
            row_valid  <= 1'b1;
          end else if (lin.lin_ready) begin
            row_valid <= 1'b0;
            issue_cnt <= issue_cnt + 6'd1;
            state     <= last_row ? DRAIN : FETCH;
          end
        end
        DRAIN: begin
          if (collect_cnt == 6'(ROWS)) state <= FIN;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Result collection runs alongside the issue side in every active state.
      if (take_done) begin
        out_vector[collect_cnt[4:0]] <= lin.lin_result;
        collect_cnt                  <= collect_cnt + 6'd1;
      end

      if (handshake && !take_done) begin
        outstanding <= outstanding + 4'd1;
      end else if (take_done && !handshake) begin
        outstanding <= outstanding - 4'd1;
      end

      // Placed after the start-time clear so a stray result in the same
      // cycle as start still gets reported.
      if (stray_done) err <= 1'b1;
    end
  end

endmodule
